// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, purely combinational.
module muldiv_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = neg ? (~value + WIDTH'(1)) : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide producing HI/LO, one bit per cycle.
// Optional abort input enabled by defining MULDIV_ABORT_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  logic               abort_hit;
`ifdef MULDIV_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // op[0] set means unsigned, op[1] set means divide.
  logic             is_signed, a_neg, b_neg, zero_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign zero_div  = op[1] & (b == '0);

  muldiv_negate #(.WIDTH(WIDTH)) u_mag_a (.value(a), .neg(a_neg), .result(a_mag));
  muldiv_negate #(.WIDTH(WIDTH)) u_mag_b (.value(b), .neg(b_neg), .result(b_mag));

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH:0]     add_sum, rem_shift, diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {add_sum, acc_q[WIDTH-1:1]};
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift - {1'b0, opnd_q};
    div_next  = diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Result sign fixup: the wide instance handles the product or the quotient.
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH-1:0]   rem_out, res_hi, res_lo;

  assign fix_in = is_div_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;

  muldiv_negate #(.WIDTH(2 * WIDTH)) u_fix_lo (.value(fix_in), .neg(neg_lo_q), .result(fix_out));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_hi (
    .value (acc_q[2*WIDTH-1:WIDTH]),
    .neg   (neg_hi_q),
    .result(rem_out)
  );

  assign res_lo = fix_out[WIDTH-1:0];
  assign res_hi = is_div_q ? rem_out : fix_out[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !zero_div) state_d = ST_CALC;
      ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (zero_div) begin
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              is_div_q <= op[1];
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= op[1] & a_neg;
              opnd_q   <= op[1] ? b_mag : a_mag;
              acc_q    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              cnt_q    <= CW'(WIDTH - 1);
            end
          end
        end
        ST_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
        end
        ST_FIX: begin
          if (!abort_hit) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
